// File: rtl/decode_uop_queue.sv
// +----------------------------------------------------------------------------+
// | decode_uop_queue                                                           |
// | Instruction queue that expands split instructions into two ordered uops.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module decode_uop_queue #(
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2,
    parameter int DEPTH     = 8,
    parameter int DATA_W    = 64
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic [IN_WIDTH-1:0]           in_valid,
    input  logic [IN_WIDTH*DATA_W-1:0]    in_payload,
    input  logic [IN_WIDTH-1:0]           in_split,
    output logic                          in_ready,
    output logic [OUT_WIDTH-1:0]          out_valid,
    output logic [OUT_WIDTH*DATA_W-1:0]   out_payload,
    output logic [OUT_WIDTH-1:0]          out_is_inst2,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem_payload [DEPTH];
    logic [DEPTH-1:0]  r_mem_split;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_half;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_push_n;
    logic [PTR_W-1:0]  w_wr_idx [IN_WIDTH];
    logic [CNT_W-1:0]  w_ent;
    logic              w_sub;
    logic [PTR_W-1:0]  w_rd_idx;

    assign count    = r_count;
    assign in_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(IN_WIDTH);
    assign w_push   = in_ready && (|in_valid) && !flush;
    assign w_pop    = out_ready && out_valid[0] && !flush;

    // Compaction: each valid slot lands at tail plus the number of valid slots below it.
    always_comb begin
        w_push_n = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            w_wr_idx[i] = r_tail + w_push_n[PTR_W-1:0];
            if (in_valid[i]) begin
                w_push_n = w_push_n + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (in_valid[i]) begin
                    r_mem_payload[w_wr_idx[i]] <= in_payload[i*DATA_W +: DATA_W];
                    r_mem_split[w_wr_idx[i]]   <= in_split[i];
                end
            end
        end
    end

    // Walk entries from head; w_sub tracks whether the next slot is uop1 of the current entry.
    always_comb begin
        w_ent        = '0;
        w_sub        = r_half;
        w_rd_idx     = '0;
        out_valid    = '0;
        out_payload  = '0;
        out_is_inst2 = '0;
        for (int s = 0; s < OUT_WIDTH; s++) begin
            if (w_ent < r_count) begin
                w_rd_idx                          = r_head + w_ent[PTR_W-1:0];
                out_valid[s]                      = 1'b1;
                out_payload[s*DATA_W +: DATA_W]   = r_mem_payload[w_rd_idx];
                out_is_inst2[s]                   = w_sub;
                if (r_mem_split[w_rd_idx] && !w_sub) begin
                    w_sub = 1'b1;
                end else begin
                    w_sub = 1'b0;
                    w_ent = w_ent + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_half  <= 1'b0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_half  <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + w_push_n[PTR_W-1:0];
            end
            if (w_pop) begin
                r_head <= r_head + w_ent[PTR_W-1:0];
                r_half <= w_sub;
            end
            r_count <= r_count + (w_push ? w_push_n : '0) - (w_pop ? w_ent : '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_uop_queue.sv
// +----------------------------------------------------------------------------+
// | tb_decode_uop_queue                                                        |
// | Scoreboard bench for decode_uop_queue with default parameters.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_decode_uop_queue;

    localparam int IW = 2;
    localparam int OW = 2;
    localparam int DW = 64;

    logic            clk;
    logic            resetn;
    logic            flush;
    logic [IW-1:0]   in_valid;
    logic [IW*DW-1:0] in_payload;
    logic [IW-1:0]   in_split;
    logic            in_ready;
    logic [OW-1:0]   out_valid;
    logic [OW*DW-1:0] out_payload;
    logic [OW-1:0]   out_is_inst2;
    logic            out_ready;
    logic [3:0]      count;

    int tests = 0;
    int fails = 0;
    logic [DW:0] exp_q [$];

    decode_uop_queue #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(8), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .in_split(in_split),
        .in_ready(in_ready), .out_valid(out_valid), .out_payload(out_payload),
        .out_is_inst2(out_is_inst2), .out_ready(out_ready), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic rand_payload();
        in_payload = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One clock: score issued uops, record accepted pushes, advance.
    task automatic do_cycle();
        logic [DW:0] e;
        if (!flush && out_ready && out_valid[0]) begin
            for (int s = 0; s < OW; s++) begin
                if (out_valid[s]) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL uop_extra slot%0d: got %h, expected none", s, out_payload[s*DW +: DW]);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_is_inst2[s], out_payload[s*DW +: DW]} !== e) begin
                            fails++;
                            $display("FAIL uop_order slot%0d: got %0b/%h, expected %0b/%h",
                                     s, out_is_inst2[s], out_payload[s*DW +: DW], e[DW], e[DW-1:0]);
                        end
                    end
                end
            end
        end
        if (!flush && in_ready && (|in_valid)) begin
            for (int i = 0; i < IW; i++) begin
                if (in_valid[i]) begin
                    exp_q.push_back({1'b0, in_payload[i*DW +: DW]});
                    if (in_split[i]) exp_q.push_back({1'b1, in_payload[i*DW +: DW]});
                end
            end
        end
        @(posedge clk);
        #1;
        if (flush) exp_q.delete();
    endtask

    task automatic idle_inputs();
        in_valid  = '0;
        in_split  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        out_ready = 1'b1;
        for (int k = 0; k < 20 && count != 0; k++) do_cycle();
        out_ready = 1'b0;
        tests++;
        if (count !== 4'd0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: count=%0d queue=%0d, expected 0/0", count, exp_q.size());
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        idle_inputs();
        in_payload = '0;
        #3 resetn = 1'b0;
        #2;
        tests++;
        if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset: count=%0d out_valid=%b in_ready=%b, expected 0/00/1", count, out_valid, in_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] a, b;
        a = 64'hAAAA_0000_0000_0001;
        b = 64'hBBBB_0000_0000_0002;
        idle_inputs();
        in_valid = 2'b11; in_payload = {b, a};
        do_cycle();
        idle_inputs();
        tests++;
        if (count !== 4'd2 || out_valid !== 2'b11 || out_payload !== {b, a} || out_is_inst2 !== 2'b00) begin
            fails++;
            $display("FAIL basic_push: count=%0d valid=%b inst2=%b pay=%h, expected 2/11/00/%h",
                     count, out_valid, out_is_inst2, out_payload, {b, a});
        end
        drain();
    endtask

    task automatic test_split();
        logic [DW-1:0] m, c;
        m = 64'h1234_5678_9ABC_DEF0;
        c = 64'hCCCC_CCCC_0000_0003;
        idle_inputs();
        in_valid = 2'b11; in_split = 2'b01; in_payload = {c, m};
        do_cycle();
        idle_inputs();
        tests++;
        if (out_valid !== 2'b11 || out_is_inst2 !== 2'b10 || out_payload !== {m, m}) begin
            fails++;
            $display("FAIL split_pair: valid=%b inst2=%b pay=%h, expected 11/10/%h", out_valid, out_is_inst2, out_payload, {m, m});
        end
        out_ready = 1'b1;
        do_cycle();
        tests++;
        if (out_valid !== 2'b01 || out_is_inst2[0] !== 1'b0 || out_payload[DW-1:0] !== c || count !== 4'd1) begin
            fails++;
            $display("FAIL split_next: valid=%b inst2=%b pay=%h count=%0d, expected 01/0/%h/1",
                     out_valid, out_is_inst2, out_payload[DW-1:0], count, c);
        end
        do_cycle();
        tests++;
        if (count !== 4'd0) begin
            fails++;
            $display("FAIL split_end: count=%0d, expected 0", count);
        end
    endtask

    task automatic test_straddle();
        logic [DW-1:0] a, m;
        a = 64'h0A0A_0A0A_0A0A_0A0A;
        m = 64'h4D4D_4D4D_4D4D_4D4D;
        idle_inputs();
        in_valid = 2'b11; in_split = 2'b10; in_payload = {m, a};
        do_cycle();
        idle_inputs();
        out_ready = 1'b1;
        tests++;
        if (out_valid !== 2'b11 || out_is_inst2 !== 2'b00 || out_payload !== {m, a}) begin
            fails++;
            $display("FAIL straddle_c1: valid=%b inst2=%b pay=%h, expected 11/00/%h", out_valid, out_is_inst2, out_payload, {m, a});
        end
        do_cycle();
        tests++;
        if (out_valid !== 2'b01 || out_is_inst2[0] !== 1'b1 || out_payload[DW-1:0] !== m || count !== 4'd1) begin
            fails++;
            $display("FAIL straddle_c2: valid=%b inst2=%b pay=%h count=%0d, expected 01/1/%h/1",
                     out_valid, out_is_inst2, out_payload[DW-1:0], count, m);
        end
        do_cycle();
        tests++;
        if (count !== 4'd0 || out_valid !== 2'b00 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL straddle_end: count=%0d valid=%b queue=%0d, expected 0/00/0", count, out_valid, exp_q.size());
        end
    endtask

    task automatic test_fill_wrap();
        idle_inputs();
        in_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            rand_payload();
            do_cycle();
        end
        tests++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL full: count=%0d in_ready=%b, expected 8/0", count, in_ready);
        end
        in_valid = '0; out_ready = 1'b1;
        do_cycle();
        in_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            rand_payload();
            do_cycle();
            tests++;
            if (count !== 4'd6) begin
                fails++;
                $display("FAIL stream_count cycle%0d: count=%0d, expected 6", k, count);
            end
        end
        drain();
        in_valid = 2'b01; rand_payload();
        do_cycle();
        in_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            rand_payload();
            do_cycle();
        end
        tests++;
        if (count !== 4'd7 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL odd_full: count=%0d in_ready=%b, expected 7/0", count, in_ready);
        end
        drain();
    endtask

    task automatic test_compact();
        logic [DW-1:0] x;
        x = 64'hFEED_FACE_CAFE_BEEF;
        idle_inputs();
        in_valid = 2'b10; in_payload = {x, 64'hDEAD_DEAD_DEAD_DEAD};
        do_cycle();
        idle_inputs();
        tests++;
        if (count !== 4'd1 || out_valid !== 2'b01 || out_payload[DW-1:0] !== x) begin
            fails++;
            $display("FAIL compact: count=%0d valid=%b pay=%h, expected 1/01/%h", count, out_valid, out_payload[DW-1:0], x);
        end
        drain();
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid = 2'b11; in_split = 2'b10;
        rand_payload(); do_cycle();
        in_split = 2'b00;
        rand_payload(); do_cycle();
        rand_payload(); do_cycle();
        idle_inputs();
        out_ready = 1'b1;
        do_cycle();
        tests++;
        if (count !== 4'd5 || out_is_inst2[0] !== 1'b1) begin
            fails++;
            $display("FAIL flush_setup: count=%0d inst2=%b, expected 5/1", count, out_is_inst2[0]);
        end
        flush = 1'b1; in_valid = 2'b11; rand_payload();
        do_cycle();
        idle_inputs();
        tests++;
        if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush: count=%0d valid=%b in_ready=%b, expected 0/00/1", count, out_valid, in_ready);
        end
        in_valid = 2'b01; rand_payload();
        do_cycle();
        idle_inputs();
        tests++;
        if (out_valid !== 2'b01 || out_is_inst2[0] !== 1'b0 || out_payload[DW-1:0] !== in_payload[DW-1:0]) begin
            fails++;
            $display("FAIL flush_half: valid=%b inst2=%b pay=%h, expected 01/0/%h",
                     out_valid, out_is_inst2[0], out_payload[DW-1:0], in_payload[DW-1:0]);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        in_valid = 2'b11; in_split = 2'b01;
        rand_payload(); do_cycle();
        idle_inputs();
        out_ready = 1'b1;
        do_cycle();
        resetn = 1'b0;
        #1;
        tests++;
        if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: count=%0d valid=%b in_ready=%b, expected 0/00/1", count, out_valid, in_ready);
        end
        exp_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            in_valid  = IW'($urandom_range(0, 3));
            in_split  = IW'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            rand_payload();
            do_cycle();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_split();
        test_straddle();
        test_fill_wrap();
        test_compact();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
